gray_ptr_sync: RTL and testbench

Destination-domain receiver for a gray-coded FIFO pointer. Samples an asynchronous gray pointer through a configurable flop chain, decodes it to binary with an optional extra pipeline stage, and reports the per-cycle pointer advance. It also flags any synchronized step that changes more than one gray bit. It sits on each side of the async FIFO, feeding the full/empty comparators.

---
 rtl/gray_ptr_sync_pkg.sv | 36 +++
 rtl/gray_ptr_sync_chain.sv | 28 ++
 rtl/gray_ptr_sync.sv | 102 ++++++++++
 tb/tb_gray_ptr_sync.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/gray_ptr_sync_pkg.sv
// Shared gray-code helpers for the async FIFO pointer logic.
package gray_pkg;

  // Widest pointer the helpers handle; narrower pointers are zero-extended.
  localparam int unsigned PTR_MAX_W = 32;

  function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] g);
    logic [PTR_MAX_W-1:0] b;
    b = '0;
    b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
    for (int unsigned i = PTR_MAX_W - 1; i > 0; i--) begin
      b[i-1] = g[i-1] ^ b[i];
    end
    return b;
  endfunction

  function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic int unsigned popcount(input logic [PTR_MAX_W-1:0] x);
    int unsigned n;
    n = 0;
    for (int unsigned i = 0; i < PTR_MAX_W; i++) begin
      n += {31'b0, x[i]};
    end
    return n;
  endfunction

  // Edges from sampling gray_async to the decoded pointer appearing.
  function automatic int unsigned sync_latency(input int unsigned stages,
                                               input int unsigned pipe);
    return stages + 1 + pipe;
  endfunction

endpackage

// File: rtl/gray_ptr_sync_chain.sv
// Multi-flop synchronizer for a bus that changes at most one bit per step.
module sync_chain #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  (* async_reg = "true" *) logic [WIDTH-1:0] stage_q [STAGES];

  // Shift the asynchronous input through the flop chain.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stage_q <= '{default: '0};
    end else begin
      stage_q[0] <= d;
      for (int unsigned i = 1; i < STAGES; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q = stage_q[STAGES-1];

endmodule

// File: rtl/gray_ptr_sync.sv
// Destination-side receiver for a gray-coded FIFO pointer: synchronize,
// decode, report per-cycle advance and flag multi-bit gray steps.
module gray_ptr_sync
  import gray_pkg::*;
#(
  parameter int unsigned BITSIZE     = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned PIPE        = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [BITSIZE-1:0] gray_async,
  input  logic               err_clr,
  output logic [BITSIZE-1:0] gray_sync,
  output logic [BITSIZE-1:0] binary,
  output logic [BITSIZE-1:0] delta,
  output logic               bin_valid,
  output logic               step_err,
  output logic               err_sticky
);

  localparam int unsigned LAT   = sync_latency(SYNC_STAGES, PIPE);
  localparam int unsigned CNT_W = $clog2(LAT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LAT);

  logic [BITSIZE-1:0] dec_bin;
  logic [BITSIZE-1:0] last_in_bin;
  logic [BITSIZE-1:0] last_in_gray;
  logic [BITSIZE-1:0] out_gray;
  logic [CNT_W-1:0]   cnt;
  logic               step_next;

  sync_chain #(
    .WIDTH  (BITSIZE),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (gray_async),
    .q     (gray_sync)
  );

  assign dec_bin = BITSIZE'(gray2bin(PTR_MAX_W'(gray_sync)));

  // The gray value travels alongside its decode so the step checker sees
  // the same samples that produced binary.
  if (PIPE != 0) begin : g_pipe
    logic [BITSIZE-1:0] dec_bin_q;
    logic [BITSIZE-1:0] dec_gray_q;

    // Decode register ahead of the output stage.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        dec_bin_q  <= '0;
        dec_gray_q <= '0;
      end else begin
        dec_bin_q  <= dec_bin;
        dec_gray_q <= gray_sync;
      end
    end

    assign last_in_bin  = dec_bin_q;
    assign last_in_gray = dec_gray_q;
  end else begin : g_nopipe
    assign last_in_bin  = dec_bin;
    assign last_in_gray = gray_sync;
  end

  // Warm-up counter; saturates once the pipeline holds real samples.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (cnt != CNT_MAX) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign bin_valid = (cnt == CNT_MAX);

  // delta/step_err compare against the current output, so they are only
  // meaningful when that output was already valid before this edge.
  assign step_next = bin_valid &&
                     (popcount(PTR_MAX_W'(last_in_gray ^ out_gray)) > 1);

  // Output stage: pointer, advance, step checker and sticky flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      binary     <= '0;
      out_gray   <= '0;
      delta      <= '0;
      step_err   <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      binary     <= last_in_bin;
      out_gray   <= last_in_gray;
      delta      <= bin_valid ? last_in_bin - binary : '0;
      step_err   <= step_next;
      err_sticky <= step_next | (err_sticky & ~err_clr);
    end
  end

endmodule

// File: tb/tb_gray_ptr_sync.sv
// Bench for gray_ptr_sync: a default instance (SYNC_STAGES=2, PIPE=0) checked
// against a queue-based model, plus a SYNC_STAGES=3, PIPE=1 instance.
module tb_gray_ptr_sync;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] g0, g1;
  logic       clr0, clr1;

  logic [3:0] gs0, bin0, dl0;
  logic       v0, se0, st0;
  logic [3:0] gs1, bin1, dl1;
  logic       v1, se1, st1;

  always #5 clk = ~clk;

  gray_ptr_sync #(.BITSIZE(4), .SYNC_STAGES(2), .PIPE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .gray_async(g0), .err_clr(clr0),
    .gray_sync(gs0), .binary(bin0), .delta(dl0), .bin_valid(v0),
    .step_err(se0), .err_sticky(st0)
  );

  gray_ptr_sync #(.BITSIZE(4), .SYNC_STAGES(3), .PIPE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .gray_async(g1), .err_clr(clr1),
    .gray_sync(gs1), .binary(bin1), .delta(dl1), .bin_valid(v1),
    .step_err(se1), .err_sticky(st1)
  );

  int tests = 0;
  int fails = 0;

  // Scoreboard for dut0: gray values pushed when driven, popped when due.
  logic [3:0] q_g[$];
  logic [3:0] e_gs, e_bin, e_dl, e_gprev;
  logic       e_v, e_err, e_st;

  function automatic logic [3:0] m_g2b(input logic [3:0] g);
    logic [3:0] b;
    b[3] = g[3];
    for (int i = 2; i >= 0; i--) b[i] = g[i] ^ b[i+1];
    return b;
  endfunction

  function automatic logic [3:0] m_b2g(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic int m_ones(input logic [3:0] x);
    int n = 0;
    for (int i = 0; i < 4; i++) n += int'(x[i]);
    return n;
  endfunction

  // Drive one cycle into dut0, then advance the model to the post-edge state.
  task automatic tick(input logic [3:0] g, input logic clr, input logic rst);
    logic [3:0] ng, nb;
    g0 = g; clr0 = clr; rst_n = rst;
    @(posedge clk); #1;
    if (!rst) begin
      q_g.delete();
      e_gs = '0; e_bin = '0; e_dl = '0; e_gprev = '0;
      e_v = 1'b0; e_err = 1'b0; e_st = 1'b0;
    end else begin
      q_g.push_back(g);
      e_gs = (q_g.size() >= 2) ? q_g[q_g.size()-2] : 4'h0;
      if (q_g.size() == 3) begin
        ng = q_g.pop_front();
        nb = m_g2b(ng);
        e_dl  = e_v ? nb - e_bin : 4'h0;
        e_err = e_v && (m_ones(ng ^ e_gprev) > 1);
        e_bin = nb; e_gprev = ng; e_v = 1'b1;
      end else begin
        e_dl = 4'h0; e_err = 1'b0;
      end
      e_st = e_err | (e_st & ~clr);
    end
  endtask

  task automatic test_reset;
    for (int k = 0; k < 3; k++) tick(4'h0, 1'b0, 1'b0);
    tests++;
    if ({gs0, bin0, dl0, v0, se0, st0} !== 15'h0) begin
      fails++; $display("FAIL reset0 got=%h exp=0", {gs0, bin0, dl0, v0, se0, st0});
    end
    tests++;
    if ({gs1, bin1, dl1, v1, se1, st1} !== 15'h0) begin
      fails++; $display("FAIL reset1 got=%h exp=0", {gs1, bin1, dl1, v1, se1, st1});
    end
    for (int k = 1; k <= 6; k++) begin
      tick(4'h0, 1'b0, 1'b1);
      tests++;
      if (v0 !== (k >= 3)) begin
        fails++; $display("FAIL warmup0 edge=%0d got=%b exp=%b", k, v0, (k >= 3));
      end
      tests++;
      if (v1 !== (k >= 5)) begin
        fails++; $display("FAIL warmup1 edge=%0d got=%b exp=%b", k, v1, (k >= 5));
      end
      tests++;
      if ({bin0, dl0, se0, st0} !== 10'h0) begin
        fails++; $display("FAIL warmup_zero edge=%0d got=%h exp=0", k, {bin0, dl0, se0, st0});
      end
    end
  endtask

  task automatic test_count;
    int ones = 0;
    for (int i = 0; i < 19; i++) begin
      tick((i < 16) ? m_b2g(4'(i)) : 4'h0, 1'b0, 1'b1);
      tests++;
      if ({gs0, bin0, dl0, v0, se0} !== {e_gs, e_bin, e_dl, e_v, e_err}) begin
        fails++;
        $display("FAIL count i=%0d got gs=%h bin=%h dl=%h v=%b se=%b exp gs=%h bin=%h dl=%h v=%b se=%b",
                 i, gs0, bin0, dl0, v0, se0, e_gs, e_bin, e_dl, e_v, e_err);
      end
      if (dl0 === 4'h1) ones++;
      tests++;
      if (se0 !== 1'b0) begin
        fails++; $display("FAIL count_step_err i=%0d got=%b exp=0", i, se0);
      end
    end
    tests++;
    if (ones != 16) begin
      fails++; $display("FAIL wrap_deltas got=%0d exp=16", ones);
    end
  endtask

  task automatic test_illegal;
    int pulses = 0;
    logic [3:0] bin_at_pulse = 4'hx;
    for (int i = 0; i < 5; i++) begin
      tick(4'h3, 1'b0, 1'b1);
      tests++;
      if ({bin0, dl0, se0, st0} !== {e_bin, e_dl, e_err, e_st}) begin
        fails++;
        $display("FAIL illegal i=%0d got bin=%h dl=%h se=%b st=%b exp bin=%h dl=%h se=%b st=%b",
                 i, bin0, dl0, se0, st0, e_bin, e_dl, e_err, e_st);
      end
      if (se0 === 1'b1) begin
        pulses++; bin_at_pulse = bin0;
      end
    end
    tests++;
    if (pulses != 1 || bin_at_pulse !== 4'h2) begin
      fails++; $display("FAIL illegal_pulse got n=%0d bin=%h exp n=1 bin=2", pulses, bin_at_pulse);
    end
    tests++;
    if (st0 !== 1'b1) begin
      fails++; $display("FAIL sticky_hold got=%b exp=1", st0);
    end
  endtask

  task automatic test_clear;
    // 3 -> 0 is another two-bit step; its pulse lands on the third tick.
    tick(4'h0, 1'b0, 1'b1);
    tick(4'h0, 1'b0, 1'b1);
    tick(4'h0, 1'b1, 1'b1);
    tests++;
    if ({se0, st0} !== {e_err, e_st} || {se0, st0} !== 2'b11) begin
      fails++; $display("FAIL clr_vs_set got se=%b st=%b exp se=1 st=1", se0, st0);
    end
    tick(4'h0, 1'b1, 1'b1);
    tests++;
    if ({se0, st0} !== 2'b00) begin
      fails++; $display("FAIL clr_alone got se=%b st=%b exp se=0 st=0", se0, st0);
    end
  endtask

  task automatic test_midreset;
    int pulses = 0;
    for (int i = 0; i < 6; i++) tick(m_b2g(4'(i)), 1'b0, 1'b1);
    tick(m_b2g(4'd6), 1'b0, 1'b0);
    tests++;
    if ({gs0, bin0, dl0, v0, se0, st0} !== 15'h0) begin
      fails++; $display("FAIL midreset got=%h exp=0", {gs0, bin0, dl0, v0, se0, st0});
    end
    for (int i = 7; i < 16; i++) begin
      tick(m_b2g(4'(i)), 1'b0, 1'b1);
      tests++;
      if ({gs0, bin0, dl0, v0, se0} !== {e_gs, e_bin, e_dl, e_v, e_err}) begin
        fails++;
        $display("FAIL resume i=%0d got gs=%h bin=%h dl=%h v=%b exp gs=%h bin=%h dl=%h v=%b",
                 i, gs0, bin0, dl0, v0, e_gs, e_bin, e_dl, e_v);
      end
      if (se0 === 1'b1) pulses++;
    end
    tests++;
    if (pulses != 0 || v0 !== 1'b1) begin
      fails++; $display("FAIL resume_clean got n=%0d v=%b exp n=0 v=1", pulses, v0);
    end
  endtask

  task automatic test_pipe;
    g1 = 4'h1;
    for (int k = 1; k <= 6; k++) begin
      tick(g0, 1'b0, 1'b1);
      tests++;
      if (k < 5 && bin1 !== 4'h0) begin
        fails++; $display("FAIL pipe_early edge=%0d got=%h exp=0", k, bin1);
      end else if (k == 5 && {bin1, dl1} !== 8'h11) begin
        fails++; $display("FAIL pipe_arrive got bin=%h dl=%h exp bin=1 dl=1", bin1, dl1);
      end else if (k == 6 && {bin1, dl1} !== 8'h10) begin
        fails++; $display("FAIL pipe_steady got bin=%h dl=%h exp bin=1 dl=0", bin1, dl1);
      end
      tests++;
      if (se1 !== 1'b0 || st1 !== 1'b0) begin
        fails++; $display("FAIL pipe_err edge=%0d got se=%b st=%b exp 0", k, se1, st1);
      end
    end
  endtask

  initial begin
    g0 = 4'h0; g1 = 4'h0; clr0 = 1'b0; clr1 = 1'b0; rst_n = 1'b0;
    e_gs = '0; e_bin = '0; e_dl = '0; e_gprev = '0;
    e_v = 1'b0; e_err = 1'b0; e_st = 1'b0;
    #1;
    test_reset;
    test_count;
    test_illegal;
    test_clear;
    test_midreset;
    test_pipe;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
